ft245_responder: RTL and testbench
==================================

# ft245_responder

Device-side emulation of the FT245-style parallel FIFO link that the SoC's UART port drives: it presents `rxf_n`/`txe_n`, answers `rd_n`/`wr_n` strobes, and drives or latches the 8-bit data bus exactly as the USB FIFO chip does. It sits on the far end of that link, either as a loopback/bring-up peer on a second FPGA or as the synthesizable bus model in system benches. It buffers bytes in two internal FIFOs and exposes them to local logic as valid/ready byte streams.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, ≥2.
- `RXF_GAP`, 2: cycles `ft_rxf_n` stays high after a read completes; ≥1.
- `TXE_GAP`, 2: cycles `ft_txe_n` stays high after a write completes; ≥1.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ft_data_i`  in  8  bus value from pad.
- `ft_data_o`  out  8  byte driven to host during a read.
- `ft_data_oe`  out  1  pad output enable for `ft_data_o`.
- `ft_rd_n`  in  1  host read strobe, active-low.
- `ft_wr_n`  in  1  host write strobe, active-low.
- `ft_rxf_n`  out  1  low = byte available for host.
- `ft_txe_n`  out  1  low = space available for host write.
- `rx_in_data`  in  8  local byte to send to host.
- `rx_in_valid`  in  1  push request.
- `rx_in_ready`  out  1  rx FIFO not full.
- `tx_out_data`  out  8  oldest byte written by host.
- `tx_out_valid`  out  1  tx FIFO not empty.
- `tx_out_ready`  in  1  local pop.
- `proto_err`  out  1  one-cycle pulse on illegal strobe.

## Operation
- All `ft_*` inputs are same-domain; the caller synchronizes them beforehand.
- rx FIFO: push when `rx_in_valid & rx_in_ready`; pop only by the read FSM. Push and pop in the same cycle are both honoured; count unchanged.
- tx FIFO: push only by the write FSM; pop when `tx_out_valid & tx_out_ready`. `tx_out_data` shows the head combinationally. Same-cycle push/pop are both honoured.
- Read FSM `R_IDLE` → `R_DRIVE` → `R_GAP`:
  - `R_IDLE`: `ft_rxf_n = (rx_count == 0)`. If `ft_rd_n == 0` and `ft_rxf_n == 0`: register head into `ft_data_o`, set `ft_data_oe = 1`, pop, go to `R_DRIVE`. If `ft_rd_n == 0` and `ft_rxf_n == 1`: pulse `proto_err`, stay.
  - `R_DRIVE`: `ft_rxf_n = 1`, bus held. When `ft_rd_n == 1`: clear `ft_data_oe`, load gap counter with `RXF_GAP`, go to `R_GAP`.
  - `R_GAP`: `ft_rxf_n = 1`. Decrement; at 1 → `R_IDLE`. `ft_rd_n` is ignored here.
- Write FSM `W_IDLE` → `W_LOW` → `W_GAP`:
  - `W_IDLE`: `ft_txe_n = (tx_count == DEPTH)`. If `ft_wr_n == 0` and `ft_txe_n == 0`: push `ft_data_i` sampled in that cycle (falling-edge capture), go to `W_LOW`. If `ft_wr_n == 0` and `ft_txe_n == 1`: pulse `proto_err`, drop the byte.
  - `W_LOW`: `ft_txe_n = 1`. When `ft_wr_n == 1`: load `TXE_GAP`, go to `W_GAP`.
  - `W_GAP`: `ft_txe_n = 1`. Count down as in the read FSM, then → `W_IDLE`.
- Read and write FSMs are independent. Simultaneous `rd_n` and `wr_n` both proceed.
- `proto_err` is the OR of both error sources.
- Wrap-around: FIFO pointers are `log2(DEPTH)` bits with a separate count of `log2(DEPTH)+1` bits. Full is `count == DEPTH`.

## Timing
- Reset (`rst == 0` at a clock edge) applies to the whole block, including mid-transfer:
  - both FSMs go to IDLE and both FIFOs empty.
  - `ft_data_oe = 0`, `ft_data_o = 0`, `ft_rxf_n = 1`, `ft_txe_n = 1`, `proto_err = 0`.
  - `rx_in_ready = 0` during reset.
  - `tx_out_valid = 0`.
- `ft_rxf_n`, `ft_txe_n`, `ft_data_o`, `ft_data_oe` and `proto_err` are registered.
- First cycle after reset release: `ft_txe_n` goes low. `rx_in_ready` goes high.
- Latency:
  - rx push → `ft_rxf_n` low: 2 cycles (FIFO write, then flag register).
  - `ft_rd_n` first sampled low → data valid with `oe` high: 1 cycle. The host must hold `rd_n` low ≥2 cycles.
  - `ft_rd_n` sampled high → `oe` low: 1 cycle.
  - Read-to-read minimum: 1 + `RXF_GAP` + 1 cycles after `rd_n` rises.
  - Write push → `tx_out_valid`: 1 cycle.
  - `ft_txe_n` rises 1 cycle after `wr_n` is sampled low.

## Test plan
- Reset, push `0xA5` on rx. Required:
  - `ft_rxf_n` low 2 cycles later.
  - Pulse `rd_n` low for 3 cycles: `ft_data_o = 0xA5` and `oe = 1` from cycle +1 until 1 cycle after `rd_n` rises.
  - `ft_rxf_n` high for exactly `RXF_GAP` cycles after that, then stays high because the FIFO is empty.
- Host writes `0x3C`, `0x00`, `0xFF` with legal spacing. Required: `tx_out_data` presents them in order; `ft_txe_n` high for `1 + TXE_GAP` cycles after each `wr_n` rise.
- Fill tx to `DEPTH` with `tx_out_ready = 0`. Required:
  - `ft_txe_n` stays high.
  - An extra `wr_n` pulse raises `proto_err` for 1 cycle and count stays `DEPTH`.
  - One pop → `ft_txe_n` low again.
- `rd_n` low while rx is empty. Required: `proto_err` pulse, `oe` stays 0, no pointer change.
- Push and read 3×`DEPTH` bytes through rx back-to-back (values 0..47). Required: correct order across pointer wrap; `rx_in_ready` low only when count = `DEPTH`.
- Assert `rst = 0` during `R_DRIVE` and `W_LOW`. Required: next cycle `oe = 0`, both flags high, FIFOs empty; normal operation after release.

Source files
------------

// File: rtl/ft245_responder_if.sv
// Bus bundle between the FT245-style host link / local byte streams and the responder.
// Debug state fields expose both FSMs for checkers.
interface ft245_responder_if;
    logic [7:0] ft_data_i;
    logic [7:0] ft_data_o;
    logic       ft_data_oe;
    logic       ft_rd_n;
    logic       ft_wr_n;
    logic       ft_rxf_n;
    logic       ft_txe_n;
    // Local streams: a byte moves on a rising clock edge where valid and ready are
    // both high; valid may not depend on ready, and data is stable while valid is high.
    logic [7:0] rx_in_data;
    logic       rx_in_valid;
    logic       rx_in_ready;
    logic [7:0] tx_out_data;
    logic       tx_out_valid;
    logic       tx_out_ready;
    logic       proto_err;
    logic [1:0] rd_state;
    logic [1:0] wr_state;

    modport master (
        output ft_data_i, ft_rd_n, ft_wr_n, rx_in_data, rx_in_valid, tx_out_ready,
        input  ft_data_o, ft_data_oe, ft_rxf_n, ft_txe_n, rx_in_ready,
               tx_out_data, tx_out_valid, proto_err, rd_state, wr_state
    );

    modport slave (
        input  ft_data_i, ft_rd_n, ft_wr_n, rx_in_data, rx_in_valid, tx_out_ready,
        output ft_data_o, ft_data_oe, ft_rxf_n, ft_txe_n, rx_in_ready,
               tx_out_data, tx_out_valid, proto_err, rd_state, wr_state
    );
endinterface

// File: rtl/ft245_responder.sv
// Device side of an FT245-style parallel FIFO link: rx FIFO feeds host reads,
// host writes fill the tx FIFO, each direction run by its own small FSM.
module ft245_responder #(
    parameter int DEPTH   = 16,
    parameter int RXF_GAP = 2,
    parameter int TXE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    ft245_responder_if.slave bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE  = (AW + 1)'(1);
    localparam logic [7:0]    RGAP = 8'(RXF_GAP);
    localparam logic [7:0]    WGAP = 8'(TXE_GAP);

    typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_GAP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_LOW, W_GAP} wr_state_t;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic [AW:0]   rx_count, tx_count;
    logic          rx_push, rx_pop, tx_push, tx_pop;

    rd_state_t  rd_state, rd_state_d;
    wr_state_t  wr_state, wr_state_d;
    logic [7:0] rd_gap, rd_gap_d, wr_gap, wr_gap_d;
    logic [7:0] data_o_q;
    logic       oe_q, oe_d, rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
    logic       rd_err, wr_err, err_q;

    assign bus.rx_in_ready  = rst && (rx_count != FULL);
    assign bus.tx_out_valid = (tx_count != '0);
    assign bus.tx_out_data  = tx_mem[tx_rptr];
    assign bus.ft_data_o    = data_o_q;
    assign bus.ft_data_oe   = oe_q;
    assign bus.ft_rxf_n     = rxf_n_q;
    assign bus.ft_txe_n     = txe_n_q;
    assign bus.proto_err    = err_q;
    assign bus.rd_state     = rd_state;
    assign bus.wr_state     = wr_state;

    assign rx_push = bus.rx_in_valid && bus.rx_in_ready;
    assign tx_pop  = bus.tx_out_valid && bus.tx_out_ready;

    // Flags use the registered count, so a push shows on rxf_n one cycle after the FIFO write.
    always_comb begin
        rd_state_d = rd_state;
        rd_gap_d   = rd_gap;
        oe_d       = oe_q;
        rxf_n_d    = 1'b1;
        rx_pop     = 1'b0;
        rd_err     = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                if (!bus.ft_rd_n) begin
                    if (!rxf_n_q) begin
                        rx_pop     = 1'b1;
                        oe_d       = 1'b1;
                        rd_state_d = R_DRIVE;
                    end else begin
                        rd_err = 1'b1;
                    end
                end
            end
            R_DRIVE: begin
                if (bus.ft_rd_n) begin
                    oe_d       = 1'b0;
                    rd_gap_d   = RGAP;
                    rd_state_d = R_GAP;
                end
            end
            R_GAP: begin
                rd_gap_d = rd_gap - 8'd1;
                if (rd_gap <= 8'd1) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_state_d == R_IDLE) rxf_n_d = (rx_count == '0);
    end

    always_comb begin
        wr_state_d = wr_state;
        wr_gap_d   = wr_gap;
        txe_n_d    = 1'b1;
        tx_push    = 1'b0;
        wr_err     = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                if (!bus.ft_wr_n) begin
                    if (!txe_n_q) begin
                        tx_push    = 1'b1;
                        wr_state_d = W_LOW;
                    end else begin
                        wr_err = 1'b1;
                    end
                end
            end
            W_LOW: begin
                if (bus.ft_wr_n) begin
                    wr_gap_d   = WGAP;
                    wr_state_d = W_GAP;
                end
            end
            W_GAP: begin
                wr_gap_d = wr_gap - 8'd1;
                if (wr_gap <= 8'd1) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (wr_state_d == W_IDLE) txe_n_d = (tx_count == FULL);
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= bus.rx_in_data;
        if (tx_push) tx_mem[tx_wptr] <= bus.ft_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
            rd_gap   <= '0;
            wr_gap   <= '0;
            data_o_q <= '0;
            oe_q     <= 1'b0;
            rxf_n_q  <= 1'b1;
            txe_n_q  <= 1'b1;
            err_q    <= 1'b0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            rd_state <= rd_state_d;
            wr_state <= wr_state_d;
            rd_gap   <= rd_gap_d;
            wr_gap   <= wr_gap_d;
            oe_q     <= oe_d;
            rxf_n_q  <= rxf_n_d;
            txe_n_q  <= txe_n_d;
            err_q    <= rd_err || wr_err;
            if (rx_pop) data_o_q <= rx_mem[rx_rptr];
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + ONE;
                2'b01:   rx_count <= rx_count - ONE;
                default: rx_count <= rx_count;
            endcase
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + ONE;
                2'b01:   tx_count <= tx_count - ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end
endmodule

// File: tb/tb_ft245_responder.sv
// Self-checking bench for ft245_responder: directed host/local traffic, expected
// bytes queued at issue time and compared by a monitor when the DUT presents them.
module tb_ft245_responder;
    localparam int DEPTH   = 16;
    localparam int RXF_GAP = 2;
    localparam int TXE_GAP = 2;

    logic clk;
    logic rst;
    ft245_responder_if bus ();

    ft245_responder #(.DEPTH(DEPTH), .RXF_GAP(RXF_GAP), .TXE_GAP(TXE_GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_tx_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int err_exp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: host read bytes appear when oe rises, tx bytes on handshake.
    initial begin : monitor
        logic oe_prev;
        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ft_data_oe === 1'b1 && !oe_prev) begin
                if (exp_rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd_extra: got %0h expected no read data", bus.ft_data_o);
                end else begin
                    check("rd_data", bus.ft_data_o, exp_rd_q.pop_front());
                end
            end
            if (bus.tx_out_valid === 1'b1 && bus.tx_out_ready === 1'b1) begin
                if (exp_tx_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_extra: got %0h expected no tx data", bus.tx_out_data);
                end else begin
                    check("tx_data", bus.tx_out_data, exp_tx_q.pop_front());
                end
            end
            if (bus.proto_err === 1'b1) err_seen++;
            oe_prev = (bus.ft_data_oe === 1'b1);
        end
    end

    task automatic rx_push(input logic [7:0] b);
        check("rx_ready", bus.rx_in_ready, 1'b1);
        exp_rd_q.push_back(b);
        bus.rx_in_data  = b;
        bus.rx_in_valid = 1'b1;
        tick(1);
        bus.rx_in_valid = 1'b0;
    endtask

    task automatic wait_rxf_low(input int max, output int k);
        k = 0;
        while (bus.ft_rxf_n !== 1'b0 && k < max) begin
            tick(1);
            k++;
        end
    endtask

    task automatic wait_txe_low(input int max, output int k);
        k = 0;
        while (bus.ft_txe_n !== 1'b0 && k < max) begin
            tick(1);
            k++;
        end
    endtask

    // Returns one cycle after the edge that sampled rd_n high again.
    task automatic host_read(input int hold, input logic [7:0] exp_b);
        bus.ft_rd_n = 1'b0;
        tick(1);
        check("rd_oe_rise", bus.ft_data_oe, 1'b1);
        check("rd_rxf_busy", bus.ft_rxf_n, 1'b1);
        tick(hold - 1);
        bus.ft_rd_n = 1'b1;
        check("rd_oe_hold", bus.ft_data_oe, 1'b1);
        check("rd_data_hold", bus.ft_data_o, exp_b);
        tick(1);
        check("rd_oe_drop", bus.ft_data_oe, 1'b0);
    endtask

    task automatic host_write(input logic [7:0] b, input int hold);
        exp_tx_q.push_back(b);
        bus.ft_data_i = b;
        bus.ft_wr_n   = 1'b0;
        tick(1);
        check("wr_txe_rise", bus.ft_txe_n, 1'b1);
        check("wr_tx_valid", bus.tx_out_valid, 1'b1);
        tick(hold - 1);
        bus.ft_wr_n = 1'b1;
        tick(1);
        check("wr_txe_gap_hi", bus.ft_txe_n, 1'b1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int k;
        logic [7:0] v;
        bus.ft_data_i    = 8'h00;
        bus.ft_rd_n      = 1'b1;
        bus.ft_wr_n      = 1'b1;
        bus.rx_in_data   = 8'h00;
        bus.rx_in_valid  = 1'b0;
        bus.tx_out_ready = 1'b0;
        rst = 1'b0;
        tick(2);
        check("rst_oe", bus.ft_data_oe, 1'b0);
        check("rst_data_o", bus.ft_data_o, 8'h00);
        check("rst_rxf", bus.ft_rxf_n, 1'b1);
        check("rst_txe", bus.ft_txe_n, 1'b1);
        check("rst_err", bus.proto_err, 1'b0);
        check("rst_rx_ready", bus.rx_in_ready, 1'b0);
        check("rst_tx_valid", bus.tx_out_valid, 1'b0);
        rst = 1'b1;
        tick(1);
        check("rel_txe", bus.ft_txe_n, 1'b0);
        check("rel_rx_ready", bus.rx_in_ready, 1'b1);
        check("rel_rxf", bus.ft_rxf_n, 1'b1);

        // Single byte to host: flag latency, 3-cycle read, gap, empty afterwards.
        rx_push(8'hA5);
        check("rxf_lat1", bus.ft_rxf_n, 1'b1);
        tick(1);
        check("rxf_lat2", bus.ft_rxf_n, 1'b0);
        host_read(3, 8'hA5);
        check("rxf_gap1", bus.ft_rxf_n, 1'b1);
        tick(1);
        check("rxf_gap2", bus.ft_rxf_n, 1'b1);
        tick(1);
        check("rxf_empty", bus.ft_rxf_n, 1'b1);
        check("rd_idle", bus.rd_state, 2'd0);

        // Host writes with legal spacing, drained immediately.
        bus.tx_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: v = 8'h3C;
                1: v = 8'h00;
                default: v = 8'hFF;
            endcase
            host_write(v, 2);
            wait_txe_low(8, k);
            check("txe_gap", k, TXE_GAP);
        end
        tick(1);
        bus.tx_out_ready = 1'b0;
        check("tx_drained", bus.tx_out_valid, 1'b0);

        // Fill tx to DEPTH with no local pops.
        for (int i = 0; i < DEPTH; i++) begin
            host_write(8'h10 + 8'(i), 2);
            if (i < DEPTH - 1) begin
                wait_txe_low(8, k);
                check("fill_txe_gap", k, TXE_GAP);
            end
        end
        tick(4);
        check("full_txe", bus.ft_txe_n, 1'b1);
        check("full_wr_idle", bus.wr_state, 2'd0);
        bus.ft_data_i = 8'hEE;
        bus.ft_wr_n   = 1'b0;
        err_exp++;
        tick(1);
        check("full_err", bus.proto_err, 1'b1);
        bus.ft_wr_n = 1'b1;
        tick(1);
        check("full_err_pulse", bus.proto_err, 1'b0);
        check("full_txe_hold", bus.ft_txe_n, 1'b1);
        check("full_wr_idle2", bus.wr_state, 2'd0);
        bus.tx_out_ready = 1'b1;
        tick(1);
        bus.tx_out_ready = 1'b0;
        check("pop_txe_lag", bus.ft_txe_n, 1'b1);
        tick(1);
        check("pop_txe_low", bus.ft_txe_n, 1'b0);
        bus.tx_out_ready = 1'b1;
        tick(DEPTH - 1);
        bus.tx_out_ready = 1'b0;
        check("fill_drained", bus.tx_out_valid, 1'b0);
        check("fill_q_empty", exp_tx_q.size(), 0);

        // Read while rx empty.
        bus.ft_rd_n = 1'b0;
        err_exp++;
        tick(1);
        check("empty_rd_err", bus.proto_err, 1'b1);
        check("empty_rd_oe", bus.ft_data_oe, 1'b0);
        bus.ft_rd_n = 1'b1;
        tick(1);
        check("empty_rd_err_pulse", bus.proto_err, 1'b0);
        rx_push(8'h5A);
        wait_rxf_low(8, k);
        check("ptr_rxf", bus.ft_rxf_n, 1'b0);
        host_read(2, 8'h5A);
        tick(3);

        // 3*DEPTH bytes through rx across pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) rx_push(8'(r * DEPTH + i));
            check("rx_full_ready", bus.rx_in_ready, 1'b0);
            wait_rxf_low(8, k);
            check("rx_rxf_low", bus.ft_rxf_n, 1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                host_read(2, 8'(r * DEPTH + i));
                if (i == 0) check("rx_ready_after_pop", bus.rx_in_ready, 1'b1);
                if (i < DEPTH - 1) begin
                    wait_rxf_low(8, k);
                    check("rxf_gap", k, RXF_GAP);
                end
            end
            tick(4);
            check("rx_empty_rxf", bus.ft_rxf_n, 1'b1);
        end

        // Reset in the middle of a read and a write.
        rx_push(8'h77);
        wait_rxf_low(8, k);
        bus.ft_data_i = 8'h99;
        bus.ft_rd_n   = 1'b0;
        bus.ft_wr_n   = 1'b0;
        tick(1);
        check("mid_rd_drive", bus.rd_state, 2'd1);
        check("mid_wr_low", bus.wr_state, 2'd1);
        rst = 1'b0;
        tick(1);
        check("mid_rst_oe", bus.ft_data_oe, 1'b0);
        check("mid_rst_rxf", bus.ft_rxf_n, 1'b1);
        check("mid_rst_txe", bus.ft_txe_n, 1'b1);
        check("mid_rst_tx_valid", bus.tx_out_valid, 1'b0);
        check("mid_rst_rx_ready", bus.rx_in_ready, 1'b0);
        check("mid_rst_data_o", bus.ft_data_o, 8'h00);
        bus.ft_rd_n = 1'b1;
        bus.ft_wr_n = 1'b1;
        rst = 1'b1;
        tick(1);
        check("post_rst_txe", bus.ft_txe_n, 1'b0);
        tick(2);
        check("post_rst_rx_empty", bus.ft_rxf_n, 1'b1);
        rx_push(8'h42);
        wait_rxf_low(8, k);
        check("post_rst_rxf", bus.ft_rxf_n, 1'b0);
        host_read(2, 8'h42);
        bus.tx_out_ready = 1'b1;
        host_write(8'h24, 2);
        wait_txe_low(8, k);
        check("post_rst_txe_gap", k, TXE_GAP);
        tick(2);

        check("err_pulses", err_seen, err_exp);
        check("rd_q_empty", exp_rd_q.size(), 0);
        check("tx_q_empty", exp_tx_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
